// File: rtl/prog_loader.sv
// prog_loader: receives a program as a byte stream and writes it, one 32-bit
// word at a time, into the instruction BRAM while the CPU is held in stall.
//
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   start          - one-cycle load request (honoured in IDLE/DONE/ERROR only)
//   word_count     - words to load, latched on an accepted start
//   s_byte/s_valid - incoming byte stream; s_ready is the accept handshake
//   w_addr/w_dat   - BRAM write port (byte address, word data)
//   w_enb          - BRAM write enable, one cycle per word
//   cpu_stall      - holds the core; low only once a load has completed
//   done, err      - sticky completion / timeout-abort flags
//   words_written  - words written in the current or last load
module prog_loader #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-2:0] word_count,
  input  logic [7:0]            s_byte,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [31:0]           w_dat,
  output logic                  w_enb,
  output logic                  cpu_stall,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-2:0] words_written
);

  localparam int unsigned CW        = ADDR_WIDTH - 1;
  localparam int unsigned MAX_WORDS = 1 << (ADDR_WIDTH - 2);
  localparam int unsigned TW        = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  logic [1:0]      byte_idx;
  logic [CW-1:0]   word_idx;
  logic [CW-1:0]   word_total;
  logic [31:0]     asm_word;
  logic [TW-1:0]   idle_cnt;

  // Requested length clipped to what the BRAM address range can hold.
  logic [CW-1:0]   count_sat_c;
  assign count_sat_c = (word_count > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : word_count;

  // Load sequencer; every output is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      s_ready       <= 1'b0;
      w_enb         <= 1'b0;
      w_addr        <= '0;
      w_dat         <= '0;
      cpu_stall     <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
      byte_idx      <= '0;
      word_idx      <= '0;
      word_total    <= '0;
      asm_word      <= '0;
      idle_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            err           <= 1'b0;
            words_written <= '0;
            byte_idx      <= '0;
            word_idx      <= '0;
            idle_cnt      <= '0;
            if (word_count == '0) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_stall <= 1'b0;
            end else begin
              state      <= S_RECV;
              done       <= 1'b0;
              s_ready    <= 1'b1;
              cpu_stall  <= 1'b1;
              word_total <= count_sat_c;
            end
          end
        end

        S_RECV: begin
          if (s_valid) begin
            // Little-endian assembly; the fourth byte goes straight to w_dat.
            asm_word[{byte_idx, 3'b000} +: 8] <= s_byte;
            byte_idx <= byte_idx + 2'd1;
            idle_cnt <= '0;
            if (byte_idx == 2'd3) begin
              state   <= S_WRITE;
              s_ready <= 1'b0;
              w_enb   <= 1'b1;
              w_addr  <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
              w_dat   <= {s_byte, asm_word[23:0]};
            end
          end else if ((TIMEOUT_CYCLES != 0) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
            // Stream stalled too long: abandon the partial word.
            state    <= S_ERROR;
            s_ready  <= 1'b0;
            err      <= 1'b1;
            byte_idx <= '0;
            idle_cnt <= '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end

        S_WRITE: begin
          w_enb         <= 1'b0;
          words_written <= words_written + CW'(1);
          if (word_idx == word_total - CW'(1)) begin
            state     <= S_DONE;
            done      <= 1'b1;
            cpu_stall <= 1'b0;
          end else begin
            state    <= S_RECV;
            word_idx <= word_idx + CW'(1);
            byte_idx <= '0;
            idle_cnt <= '0;
            s_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          s_ready   <= 1'b0;
          w_enb     <= 1'b0;
          cpu_stall <= 1'b1;
        end
      endcase
    end
  end

endmodule
